// File: rtl/float_dot_seq.sv
// float_dot_seq: drives one pipelined float MAC to form bias + sum(x*w),
// interleaving MAC_LAT partial-sum lanes, then folding the lanes together.
`ifndef D_LEN
`define D_LEN 32
`endif
module float_dot_seq #(
  parameter int MAC_LAT = 7,
  parameter int LEN_W   = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [LEN_W-1:0]  len,
  input  logic [`D_LEN-1:0] bias,
  input  logic              op_valid,
  output logic              op_ready,
  input  logic [`D_LEN-1:0] op_x,
  input  logic [`D_LEN-1:0] op_w,
  output logic [`D_LEN-1:0] mac_mul_a,
  output logic [`D_LEN-1:0] mac_mul_b,
  output logic [`D_LEN-1:0] mac_add_a,
  input  logic [`D_LEN-1:0] mac_out,
  output logic              busy,
  output logic              res_valid,
  output logic [`D_LEN-1:0] res_data
);
  localparam int DW = `D_LEN;
  localparam int PW = $clog2(MAC_LAT);
  localparam int MW = $clog2(MAC_LAT + 1);
  localparam logic [DW-1:0] ONE = DW'(32'h3F80_0000);
  localparam logic [PW-1:0] PH_LAST = PW'(MAC_LAT - 1);

  typedef enum logic [2:0] {
    IDLE, ACCUM, COLLECT, REDUCE, DONE
  } state_t;

  state_t           state;
  logic [LEN_W-1:0] n;
  logic [LEN_W-1:0] k;
  logic [DW-1:0]    bias_q;
  logic [MAC_LAT-1:0] live;
  logic [PW-1:0]    ph;
  logic [MW-1:0]    m;
  logic [MW-1:0]    j;
  logic [DW-1:0]    pbuf [MAC_LAT];
  logic             hold;

  logic             emerging;
  logic             xfer;
  logic             issue;
  logic [MW-1:0]    m_nxt;

  assign emerging = live[MAC_LAT-1];
  assign op_ready = (state == ACCUM) && (k < n);
  assign xfer     = op_valid && op_ready;
  assign busy     = (state != IDLE);
  assign issue    = (state == REDUCE) && (ph == '0) && (j < m);
  assign m_nxt    = m + MW'(emerging);

  // Steer operands into the MAC for the current phase
  always_comb begin
    mac_mul_a = '0;
    mac_mul_b = '0;
    mac_add_a = '0;
    unique case (1'b1)
      state == ACCUM: begin
        if (xfer) begin
          mac_mul_a = op_x;
          mac_mul_b = op_w;
        end
        if (emerging)
          mac_add_a = mac_out;
        else if (xfer && k == '0)
          mac_add_a = bias_q;
      end
      issue: begin
        mac_mul_a = pbuf[j];
        mac_mul_b = ONE;
        mac_add_a = (j == MW'(1)) ? pbuf[0] : mac_out;
      end
      default: ;
    endcase
  end

  // Sequencer FSM, lane tracking, lane buffer and result register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      n         <= '0;
      k         <= '0;
      bias_q    <= '0;
      live      <= '0;
      ph        <= '0;
      m         <= '0;
      j         <= '0;
      hold      <= 1'b0;
      res_valid <= 1'b0;
      res_data  <= '0;
      for (int i = 0; i < MAC_LAT; i++)
        pbuf[i] <= '0;
    end else begin
      res_valid <= 1'b0;
      unique case (state)
        IDLE: begin
          live <= '0;
          k    <= '0;
          m    <= '0;
          j    <= '0;
          ph   <= '0;
          if (start) begin
            n      <= len;
            bias_q <= bias;
            if (len == '0) begin
              state <= DONE;
              hold  <= 1'b1;
            end else begin
              state <= ACCUM;
            end
          end
        end
        ACCUM: begin
          live <= {live[MAC_LAT-2:0], xfer | emerging};
          if (xfer) begin
            k <= k + 1'b1;
            if (k + 1'b1 == n) begin
              state <= COLLECT;
              ph    <= '0;
              m     <= '0;
            end
          end
        end
        COLLECT: begin
          live <= {live[MAC_LAT-2:0], 1'b0};
          if (emerging)
            pbuf[m] <= mac_out;
          m  <= m_nxt;
          ph <= ph + 1'b1;
          if (ph == PH_LAST) begin
            ph <= '0;
            j  <= MW'(1);
            if (m_nxt == MW'(1)) begin
              state     <= DONE;
              res_valid <= 1'b1;
              res_data  <= emerging ? mac_out : pbuf[0];
            end else begin
              state <= REDUCE;
            end
          end
        end
        REDUCE: begin
          if (ph == PH_LAST) begin
            ph <= '0;
            j  <= j + 1'b1;
          end else begin
            ph <= ph + 1'b1;
          end
          if (ph == '0 && j == m) begin
            state     <= DONE;
            res_valid <= 1'b1;
            res_data  <= mac_out;
          end
        end
        DONE: begin
          if (hold) begin
            hold      <= 1'b0;
            res_valid <= 1'b1;
            res_data  <= bias_q;
          end else begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_float_dot_seq.sv
// tb_float_dot_seq: random operand streams checked against an exact
// dot-product model, with a behavioural pipelined MAC around the DUT.
module tb_float_dot_seq;
  localparam int L  = 7;
  localparam int LW = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          start = 1'b0;
  logic [LW-1:0] len = '0;
  logic [31:0]   bias = '0;
  logic          op_valid = 1'b0;
  logic          op_ready;
  logic [31:0]   op_x = '0;
  logic [31:0]   op_w = '0;
  logic [31:0]   mac_mul_a;
  logic [31:0]   mac_mul_b;
  logic [31:0]   mac_add_a;
  logic [31:0]   mac_out;
  logic          busy;
  logic          res_valid;
  logic [31:0]   res_data;

  logic [31:0]   pipe [L];
  real           gx [64];
  real           gw [64];
  int            n_chk = 0;
  int            n_pass = 0;

  always #5 clk = ~clk;

  float_dot_seq #(.MAC_LAT(L), .LEN_W(LW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .len(len),
    .bias(bias), .op_valid(op_valid), .op_ready(op_ready),
    .op_x(op_x), .op_w(op_w), .mac_mul_a(mac_mul_a),
    .mac_mul_b(mac_mul_b), .mac_add_a(mac_add_a),
    .mac_out(mac_out), .busy(busy), .res_valid(res_valid),
    .res_data(res_data)
  );

  function automatic real b2r(input logic [31:0] f);
    logic [63:0] d;
    if (f[30:23] == 8'd0) return 0.0;
    d = {f[31], {3'b000, f[30:23]} + 11'd896, f[22:0], 29'd0};
    return $bitstoreal(d);
  endfunction

  function automatic logic [31:0] r2b(input real r);
    logic [63:0] d;
    logic [10:0] e;
    d = $realtobits(r);
    if (d[62:52] == 11'd0) return {d[63], 31'd0};
    e = d[62:52] - 11'd896;
    return {d[63], e[7:0], d[51:29]};
  endfunction

  // Stand-in float_mac: L register stages, deliberately not reset
  always @(posedge clk) begin
    pipe[0] <= r2b(b2r(mac_mul_a) * b2r(mac_mul_b) + b2r(mac_add_a));
    for (int i = 1; i < L; i++)
      pipe[i] <= pipe[i-1];
  end
  assign mac_out = pipe[L-1];

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic run_op(input int n, input real bv, input int stall,
                        input int poke_at, input int abort_at);
    int          cyc;
    int          k;
    int          last;
    int          m;
    int          lat;
    bit [L-1:0]  lanes;
    bit          done;
    bit          quiet;
    real         sum;
    logic [31:0] exp_d;
    sum = bv;
    for (int i = 0; i < n; i++)
      sum += gx[i] * gw[i];
    exp_d = r2b(sum);
    cyc = 0; k = 0; last = -1; lanes = '0; done = 0; quiet = 1;
    @(posedge clk); #1;
    start = 1'b1;
    len = LW'(n);
    bias = r2b(bv);
    op_valid = 1'b0;
    while (!done && cyc < 3000) begin
      @(negedge clk);
      if (abort_at >= 0 && cyc == abort_at) begin
        rst_n = 1'b0;
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_ready", 32'(op_ready), 32'd0);
        check("rst_rvalid", 32'(res_valid), 32'd0);
        check("rst_rdata", res_data, 32'd0);
        check("rst_mac", mac_mul_a | mac_mul_b | mac_add_a, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        return;
      end
      if ((mac_mul_a | mac_mul_b | mac_add_a) != 32'd0) quiet = 0;
      check("op_ready", 32'(op_ready), 32'(cyc >= 1 && k < n));
      if (op_valid && op_ready) begin
        lanes[cyc % L] = 1'b1;
        last = cyc;
        k++;
      end
      if (res_valid) begin
        done = 1;
        m = $countones(lanes);
        lat = (n == 0) ? 2 : (m == 1) ? last + L + 1 : last + m * L + 2;
        check("res_cycle", 32'(cyc), 32'(lat));
        check("res_data", res_data, exp_d);
      end
      @(posedge clk); #1;
      cyc++;
      start = (cyc == poke_at);
      len = LW'($urandom);
      bias = $urandom;
      op_valid = (k < n) && ($urandom_range(99) >= stall);
      op_x = r2b(gx[k]);
      op_w = r2b(gw[k]);
    end
    if (!done) begin
      check("timeout", 32'd0, 32'd1);
      return;
    end
    if (n == 0) check("mac_quiet", 32'(quiet), 32'd1);
    @(negedge clk);
    check("pulse_end", 32'(res_valid), 32'd0);
    check("idle_busy", 32'(busy), 32'd0);
    check("res_hold", res_data, exp_d);
  endtask

  initial begin
    int  n;
    real bv;
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_ready", 32'(op_ready), 32'd0);
    check("reset_rvalid", 32'(res_valid), 32'd0);
    check("reset_rdata", res_data, 32'd0);
    check("reset_mac", mac_mul_a | mac_mul_b | mac_add_a, 32'd0);
    rst_n = 1'b1;

    run_op(0, 3.0, 0, -1, -1);

    gx[0] = 2.0; gw[0] = 3.0;
    run_op(1, 1.0, 0, -1, -1);

    for (int i = 0; i < 3; i++) begin
      gx[i] = real'(i + 1); gw[i] = 1.0;
    end
    run_op(3, 0.0, 0, -1, -1);

    for (int i = 0; i < 10; i++) begin
      gx[i] = real'(i + 1); gw[i] = 0.5;
    end
    run_op(10, 0.0, 40, -1, -1);

    run_op(5, 2.0, 30, 3, -1);

    run_op(10, 0.0, 0, -1, 30);
    gx[0] = 2.0; gw[0] = 3.0;
    run_op(1, 1.0, 0, -1, -1);

    repeat (14) begin
      n = $urandom_range(0, 24);
      for (int i = 0; i < 64; i++) begin
        gx[i] = real'($urandom_range(1, 16)) / 2.0;
        if ($urandom_range(1) == 1) gx[i] = -gx[i];
        case ($urandom_range(5))
          0: gw[i] = 0.5;
          1: gw[i] = 1.0;
          2: gw[i] = 2.0;
          3: gw[i] = -1.0;
          4: gw[i] = -0.25;
          default: gw[i] = 4.0;
        endcase
      end
      bv = real'($urandom_range(0, 16)) / 4.0 - 2.0;
      run_op(n, bv, $urandom_range(0, 60), -1, -1);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/float_dot_seq.md
# float_dot_seq

Sequencer that drives one `float_mac` instance to compute a neuron pre-activation `bias + Σ x[k]·w[k]` over a streamed vector of IEEE-754 single operand pairs. It sits upstream of `float_mac`: it generates `mul_a`/`mul_b`/`add_a` each cycle and consumes `mac_out`. It hides the MAC pipeline latency by interleaving `MAC_LAT` partial-sum lanes, then reduces the lanes through the same MAC. Sits between the layer controller (operand stream, start/result) and the `float_mac` instance.

## Interface
- `MAC_LAT`, 7: total `float_mac` latency, in edges from operands sampled to `mac_out` valid; must equal the instantiated MAC.
- `LEN_W`, 16: width of vector length.
- Data width is `` `D_LEN `` (32), from `extern.v`.

Ports:
- `clk` in 1: clock; single clock domain, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: begin an operation; sampled only in IDLE.
- `len` in LEN_W: vector length N; latched on `start`.
- `bias` in D_LEN: initial addend; latched on `start`.
- `op_valid` in 1: operand pair present.
- `op_ready` out 1: sequencer accepts the pair.
- `op_x`, `op_w` in D_LEN: input and weight.
- `mac_mul_a`, `mac_mul_b`, `mac_add_a` out D_LEN: to `float_mac`; combinational.
- `mac_out` in D_LEN: from `float_mac`.
- `busy` out 1: high in every state except IDLE.
- `res_valid` out 1: one-cycle pulse; result is valid.
- `res_data` out D_LEN: result; held until the next result.

## Operation
- States: IDLE, ACCUM, COLLECT, REDUCE, DONE.
- Reset (async) from any state, including mid-operation:
  - go to IDLE.
  - `busy`, `op_ready`, `res_valid` = 0; `res_data` = 0.
  - live shift register and counters cleared.
  - mac_* ports = 0.
  - In-flight MAC results are ignored.
- IDLE:
  - mac_* = 0.
  - `start` with N = 0: go to DONE with `res_data` = bias.
  - `start` with N ≥ 1: go to ACCUM and clear issue count k.
- ACCUM, handshake and slot emergence:
  - `op_ready` = 1 while k < N.
  - A transfer is `op_valid & op_ready`.
  - Live shift register `live[MAC_LAT-1:0]` advances every cycle; `emerging` = `live[MAC_LAT-1]`.
- ACCUM, transfer cycle:
  - `mac_mul_a` = op_x, `mac_mul_b` = op_w.
  - `mac_add_a` = mac_out if `emerging`; else bias if k = 0; else +0.
  - Shift in 1; k increments.
- ACCUM, stall cycle (no transfer):
  - `mac_mul_a` = `mac_mul_b` = +0.
  - `mac_add_a` = mac_out if `emerging`, else +0.
  - Shift in `emerging`. This recirculates live partial sums so lane alignment survives gaps.
- ACCUM exit: k reaches N → COLLECT, after the issue cycle of the last pair.
- COLLECT, exactly MAC_LAT cycles:
  - mac_* = 0; shift in 0.
  - Each cycle with `emerging`, append `mac_out` to buffer pbuf at index m, then m++.
  - Exit: m = 1 → DONE with acc = pbuf[0]; else → REDUCE.
- REDUCE, (m−1) rounds of MAC_LAT cycles each:
  - Round 1 issues in its first cycle: `mac_mul_a` = pbuf[1], `mac_mul_b` = 32'h3F800000 (1.0), `mac_add_a` = pbuf[0].
  - Round j ≥ 2 issues pbuf[j] × 1.0 with `mac_add_a` = mac_out (result of round j−1, valid in this cycle).
  - Non-issue cycles: mac_* = 0.
  - After the last round, `res_data` ← mac_out in the cycle that result is valid → DONE.
- DONE: `res_valid` = 1 for one cycle → IDLE.
- Boundary conditions:
  - `start` while busy: ignored.
  - `len`/`bias` changes after `start`: no effect.
  - m ≤ min(N, MAC_LAT); pbuf holds MAC_LAT entries.
  - +0 additions are exact, so stall bubbles do not alter sums.
- Summation order is lane order, then pbuf order. Results must match a model using the same association, not necessarily sequential order.

## Timing
- Numbering: cycle 0 ends at the edge sampling `start`.
- No stalls, N ≥ 1: pair k issues in cycle 1+k; COLLECT occupies cycles N+1..N+MAC_LAT.
- `res_valid` is high in:
  - cycle N+MAC_LAT+1 if m = 1;
  - cycle N+m·MAC_LAT+2 if m ≥ 2.
- N = 0: `res_valid` in cycle 2.
- Stalls delay ACCUM exit cycle-for-cycle; later phases are unchanged relative to exit.
- `op_ready` is combinational from state and k only; it never depends on `op_valid`.
- Next `start` is accepted the cycle after DONE.

## Test plan
- **N = 0:** bias = 0x40400000 (3.0) → `res_valid` in cycle 2, `res_data` = 0x40400000, no MAC activity.
- **N = 1, no stalls:** x = 2.0, w = 3.0, bias = 1.0 → `res_data` = 0x40E00000 (7.0), `res_valid` in cycle 9.
- **N = 3, no stalls:** x = {1,2,3}, w = {1,1,1}, bias = 0 → 6.0 (0x40C00000) in cycle 26. Check `op_ready` drops after the third transfer.
- **N = 10, random stalls, random valid:** x = k+1, w = 0.5, bias = 0 → 27.5 (0x41DC0000); exact result despite bubbles; m = 7.
- **Reset mid-op:** assert `rst_n` = 0 during REDUCE → all outputs 0 immediately. After release, a new N = 1 run returns the correct value with no corruption from the previous run.
- **Start while busy:** pulse `start` with a different bias during ACCUM → ignored; result uses the original bias.
